// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures period and high time of each PWM channel in clk
// cycles and streams one result per completed period over valid/ready.
// Optional build macro PWM_METER_GLITCH_FILTER_EN: a 3-sample majority-free
// filter (level moves only after 3 equal samples) after the synchronizer.

// Per-channel front end: synchronizer, edge detect, counters, pending slot.
module pwm_meter_ch #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_i,
  input  logic             enable_i,
  input  logic             drain_i,
  input  logic             ovr_clr_i,
  output logic             pend_vld_o,
  output logic [CNT_W-1:0] pend_high_o,
  output logic [CNT_W-1:0] pend_per_o,
  output logic             pend_sat_o,
  output logic             ovr_o
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_MEAS} st_e;

  st_e                    st_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_w, lvl_q, lvl_d, prev_q, rise_w, cap_w;
  logic [CNT_W-1:0]       per_q, high_q;
  logic                   psat_q;

  // Input synchronizer chain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};

  assign s_w = sync_q[SYNC_STAGES-1];

`ifdef PWM_METER_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  assign lvl_d = (s_w == hist_q[0] && s_w == hist_q[1]) ? s_w : lvl_q;
  // History of the two previous synced samples for the filter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hist_q <= '0;
    else        hist_q <= {hist_q[0], s_w};
`else
  assign lvl_d = s_w;
`endif

  // Level register plus delayed copy for rising-edge detect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      prev_q <= lvl_q;
    end

  assign rise_w = lvl_q & ~prev_q;
  assign cap_w  = enable_i && (st_q == ST_MEAS) && rise_w;

  // Channel state and saturating period/high counters; the edge cycle
  // itself is counted as cycle 1 of the new window
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      per_q  <= '0;
      high_q <= '0;
      psat_q <= 1'b0;
    end else if (!enable_i) begin
      st_q   <= ST_IDLE;
      per_q  <= '0;
      high_q <= '0;
      psat_q <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: st_q <= ST_ARM;
        ST_ARM: if (rise_w) begin
          st_q   <= ST_MEAS;
          per_q  <= CNT_W'(1);
          high_q <= CNT_W'(1);
          psat_q <= 1'b0;
        end
        default: if (rise_w) begin
          per_q  <= CNT_W'(1);
          high_q <= CNT_W'(1);
          psat_q <= 1'b0;
        end else begin
          per_q  <= (per_q == CMAX) ? per_q : per_q + CNT_W'(1);
          psat_q <= psat_q | (per_q == CMAX);
          if (lvl_q && high_q != CMAX) high_q <= high_q + CNT_W'(1);
        end
      endcase
    end

  // 1-deep pending slot; a capture beats a same-cycle drain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend_vld_o  <= 1'b0;
      pend_high_o <= '0;
      pend_per_o  <= '0;
      pend_sat_o  <= 1'b0;
    end else if (!enable_i) begin
      pend_vld_o  <= 1'b0;
    end else if (cap_w) begin
      pend_vld_o  <= 1'b1;
      pend_high_o <= high_q;
      pend_per_o  <= per_q;
      pend_sat_o  <= psat_q;
    end else if (drain_i) begin
      pend_vld_o  <= 1'b0;
    end

  // Sticky overrun: clear has priority over a same-cycle set
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                              ovr_o <= 1'b0;
    else if (ovr_clr_i)                      ovr_o <= 1'b0;
    else if (cap_w && pend_vld_o && !drain_i) ovr_o <= 1'b1;
endmodule

// Top: channel array, round-robin arbiter, single output register.
module pwm_duty_meter #(
  parameter int NCH         = 8,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   pwm_in,
  input  logic             enable,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       res_ch,
  output logic [CNT_W-1:0] res_high,
  output logic [CNT_W-1:0] res_period,
  output logic             res_sat,
  output logic [NCH-1:0]   overrun,
  input  logic             overrun_clr
);
  logic [NCH-1:0]            pv, ps, drain;
  logic [NCH-1:0][CNT_W-1:0] ph, pp;
  logic [2:0]                ptr_q, sel_w, sel_hi, sel_lo, out_ch_q;
  logic                      any_w, hi_f, load_w, out_vld_q, out_sat_q, m_sat;
  logic [CNT_W-1:0]          m_high, m_per, out_high_q, out_per_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign drain[g] = load_w && (sel_w == 3'(g));
    pwm_meter_ch #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_ch (
      .clk(clk), .rst_n(rst_n), .pwm_i(pwm_in[g]), .enable_i(enable),
      .drain_i(drain[g]), .ovr_clr_i(overrun_clr),
      .pend_vld_o(pv[g]), .pend_high_o(ph[g]), .pend_per_o(pp[g]),
      .pend_sat_o(ps[g]), .ovr_o(overrun[g]));
  end

  // Round-robin pick: lowest pending index at or after ptr, else lowest overall
  always_comb begin
    hi_f   = 1'b0;
    sel_hi = '0;
    sel_lo = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (pv[c]) sel_lo = 3'(c);
      if (pv[c] && 3'(c) >= ptr_q) begin
        hi_f   = 1'b1;
        sel_hi = 3'(c);
      end
    end
    sel_w  = hi_f ? sel_hi : sel_lo;
    any_w  = enable && (|pv);
    load_w = any_w && (!out_vld_q || res_ready);
  end

  // Data mux for the selected channel
  always_comb begin
    m_high = '0;
    m_per  = '0;
    m_sat  = 1'b0;
    for (int c = 0; c < NCH; c++)
      if (sel_w == 3'(c)) begin
        m_high = ph[c];
        m_per  = pp[c];
        m_sat  = ps[c];
      end
  end

  // Output register: reload when empty or being accepted, else hold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_ch_q   <= '0;
      out_high_q <= '0;
      out_per_q  <= '0;
      out_sat_q  <= 1'b0;
      ptr_q      <= '0;
    end else if (load_w) begin
      out_vld_q  <= 1'b1;
      out_ch_q   <= sel_w;
      out_high_q <= m_high;
      out_per_q  <= m_per;
      out_sat_q  <= m_sat;
      ptr_q      <= (sel_w == 3'(NCH - 1)) ? 3'd0 : sel_w + 3'd1;
    end else if (res_ready) begin
      out_vld_q  <= 1'b0;
    end

  assign res_valid  = out_vld_q;
  assign res_ch     = out_ch_q;
  assign res_high   = out_high_q;
  assign res_period = out_per_q;
  assign res_sat    = out_sat_q;
endmodule
